// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the 9-bit core instruction fetch front end.
package fetch_pkg;

    localparam int unsigned IW_DEF   = 9;
    localparam int unsigned PCW_DEF  = 10;
    localparam int unsigned LUTW_DEF = 5;
    localparam logic [IW_DEF-1:0] HALT_WORD_DEF = 9'h1FF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        RdNone,
        RdJump,
        RdBranch
    } redir_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read bus: fetch unit is master, IMEM is slave.
interface instr_fetch_if #(
    parameter int unsigned IW  = 9,
    parameter int unsigned PCW = 10
) ();
    logic [PCW-1:0] ImemAddr;
    logic           ImemRe;
    logic [IW-1:0]  ImemData;

    modport master (output ImemAddr, output ImemRe, input ImemData);
    modport slave  (input ImemAddr, input ImemRe, output ImemData);
endinterface

// File: rtl/branch_lut.sv
// Branch/jump target table: register array, synchronous write, asynchronous read,
// cleared by reset.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned LUTW = LUTW_DEF,
    parameter int unsigned PCW  = PCW_DEF
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            we,
    input  logic [LUTW-1:0] waddr,
    input  logic [PCW-1:0]  wdata,
    input  logic [LUTW-1:0] raddr,
    output logic [PCW-1:0]  rdata
);
    localparam int unsigned Entries = 2 ** LUTW;

    logic [PCW-1:0] mem_q [Entries];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < Entries; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, synchronous IMEM reads, branch/jump redirect with one-bubble squash,
// halt detection. Define INSTR_COUNT_EN to add the saturating InstrCount output.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned    IW        = IW_DEF,
    parameter int unsigned    PCW       = PCW_DEF,
    parameter int unsigned    LUTW      = LUTW_DEF,
    parameter logic [IW-1:0]  HALT_WORD = HALT_WORD_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Hold,
    input  logic              Branch,
    input  logic              Zero,
    input  logic              Jump,
    input  logic              LutWe,
    input  logic [LUTW-1:0]   LutAddr,
    input  logic [PCW-1:0]    LutData,
    instr_fetch_if.master     imem,
    output logic [IW-1:0]     Instr,
    output logic              InstrValid,
    output logic [PCW-1:0]    Pc,
    output logic              Done
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]       InstrCount
`endif
);
    state_e         state_q;
    logic [PCW-1:0] pc_q;
    logic [PCW-1:0] pc_cur_q;
    logic           valid_q;
    logic           done_q;

    logic           read_en;
    logic           consume;
    logic           is_halt;
    logic           redirect;
    logic           start_ok;
    logic           lut_we;
    logic [PCW-1:0] target;
    redir_e         cause;

    assign read_en  = (state_q == StRun) & ~Hold;
    assign consume  = valid_q & ~Hold;
    assign is_halt  = consume & (Instr == HALT_WORD);
    assign start_ok = Start & (state_q != StRun);
    assign lut_we   = LutWe & (state_q != StRun);

    // Halt outranks any redirect decoded from the same word.
    always_comb begin
        cause = RdNone;
        if (consume && !is_halt) begin
            if (Jump) begin
                cause = RdJump;
            end else if (Branch && Zero) begin
                cause = RdBranch;
            end
        end
    end

    assign redirect = (cause != RdNone);

    branch_lut #(
        .LUTW (LUTW),
        .PCW  (PCW)
    ) u_lut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .we      (lut_we),
        .waddr   (LutAddr),
        .wdata   (LutData),
        .raddr   (Instr[LUTW-1:0]),
        .rdata   (target)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            pc_cur_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q  <= StRun;
                        pc_q     <= '0;
                        pc_cur_q <= '0;
                        valid_q  <= 1'b0;
                        done_q   <= 1'b0;
                    end
                end
                StRun: begin
                    if (is_halt) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end else if (read_en) begin
                        // On redirect the sequential read issued now is squashed.
                        pc_q     <= redirect ? target : pc_q + PCW'(1);
                        pc_cur_q <= pc_q;
                        valid_q  <= ~redirect;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else if (start_ok) begin
            count_q <= '0;
        end else if (consume && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign InstrCount = count_q;
`endif

    assign imem.ImemAddr = pc_q;
    assign imem.ImemRe   = read_en;
    assign Instr         = imem.ImemData;
    assign InstrValid    = valid_q;
    assign Pc            = pc_cur_q;
    assign Done          = done_q;

endmodule
